// File: rtl/semver_probe.sv
`default_nettype none
// ============================================================================
// Module   : semver_probe
// Purpose  : Reads a remote version word over pipelined Wishbone B4 and
//            reports whether the major/minor fields are compatible.
// Revision : 1.0
// ============================================================================
module semver_probe #(
  parameter int G_ADDR_WIDTH = 3,
  parameter int G_VER_ADDR   = 4,
  parameter int G_EXP_MAJOR  = 1,
  parameter int G_MIN_MINOR  = 2,
  parameter int G_TIMEOUT    = 255,
  parameter int G_RETRIES    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [G_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]              wb_sel_o,
  output logic                    wb_we_o,
  output logic [31:0]             wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [31:0]             wb_dat_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    compat_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic [31:0]             version_o
);

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_REQ     = 3'd1;
  localparam logic [2:0] C_ST_WAIT    = 3'd2;
  localparam logic [2:0] C_ST_BACKOFF = 3'd3;
  localparam logic [2:0] C_ST_DONE    = 3'd4;

  localparam logic [15:0]             C_TMO_LAST  = 16'(G_TIMEOUT - 1);
  localparam logic [3:0]              C_RETRIES   = 4'(G_RETRIES);
  localparam logic [7:0]              C_EXP_MAJOR = 8'(G_EXP_MAJOR);
  localparam logic [7:0]              C_MIN_MINOR = 8'(G_MIN_MINOR);
  localparam logic [G_ADDR_WIDTH-1:0] C_VER_ADDR  = G_ADDR_WIDTH'(G_VER_ADDR);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [15:0] r_tcnt;
  logic [3:0]  r_retry;
  logic        r_compat;
  logic        r_err;
  logic        r_timeout;
  logic [31:0] r_version;

  logic w_on_bus;
  logic w_term_en;
  logic w_err;
  logic w_rty;
  logic w_ack;
  logic w_tmo;
  logic w_start;

  assign w_on_bus  = (r_state == C_ST_REQ) || (r_state == C_ST_WAIT);
  // A termination only counts once the strobe has been accepted (or after).
  assign w_term_en = ((r_state == C_ST_REQ) && !wb_stall_i) || (r_state == C_ST_WAIT);
  assign w_err     = w_term_en && wb_err_i;
  assign w_rty     = w_term_en && wb_rty_i && !wb_err_i;
  assign w_ack     = w_term_en && wb_ack_i && !wb_err_i && !wb_rty_i;
  assign w_tmo     = w_on_bus && (r_tcnt == C_TMO_LAST);
  assign w_start   = (r_state == C_ST_IDLE) && start_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; terminations outrank the timeout in the same cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (start_i) w_next_state = C_ST_REQ;
      end
      C_ST_REQ, C_ST_WAIT: begin
        if (w_err)                      w_next_state = C_ST_DONE;
        else if (w_rty)                 w_next_state = (r_retry != 4'd0) ? C_ST_BACKOFF : C_ST_DONE;
        else if (w_ack)                 w_next_state = C_ST_DONE;
        else if (w_tmo)                 w_next_state = C_ST_DONE;
        else if (r_state == C_ST_REQ && !wb_stall_i) w_next_state = C_ST_WAIT;
      end
      C_ST_BACKOFF: w_next_state = C_ST_REQ;
      C_ST_DONE:    w_next_state = C_ST_IDLE;
      default:      w_next_state = C_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wb_cyc_o = w_on_bus;
    wb_stb_o = (r_state == C_ST_REQ);
    wb_adr_o = w_on_bus ? C_VER_ADDR : '0;
    wb_sel_o = w_on_bus ? 4'hF : 4'h0;
    wb_we_o  = 1'b0;
    wb_dat_o = 32'd0;
    busy_o   = (r_state != C_ST_IDLE);
    done_o   = (r_state == C_ST_DONE);
  end

  assign compat_o  = r_compat;
  assign err_o     = r_err;
  assign timeout_o = r_timeout;
  assign version_o = r_version;

  // Counters and status; status holds from DONE until the next accepted start
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tcnt    <= 16'd0;
      r_retry   <= 4'd0;
      r_compat  <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_version <= 32'd0;
    end else begin
      if (w_start) begin
        r_tcnt    <= 16'd0;
        r_retry   <= C_RETRIES;
        r_compat  <= 1'b0;
        r_err     <= 1'b0;
        r_timeout <= 1'b0;
      end else if (r_state == C_ST_BACKOFF) begin
        r_tcnt <= 16'd0;
      end else if (w_on_bus) begin
        r_tcnt <= r_tcnt + 16'd1;
        if (w_err) begin
          r_err <= 1'b1;
        end else if (w_rty) begin
          if (r_retry != 4'd0) r_retry <= r_retry - 4'd1;
          else                 r_err   <= 1'b1;
        end else if (w_ack) begin
          r_version <= wb_dat_i;
          r_compat  <= (wb_dat_i[23:16] == C_EXP_MAJOR) && (wb_dat_i[15:8] >= C_MIN_MINOR);
        end else if (w_tmo) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_semver_probe.sv
`default_nettype none
// Testbench for semver_probe: table of probe vectors plus hand-written retry,
// timeout, ignored-start and reset sequences, checked through a scoreboard.
module tb_semver_probe;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
  logic [31:0] wb_dat_i = 32'd0;
  logic        busy_o, done_o, compat_o, err_o, timeout_o;
  logic [31:0] version_o;

  semver_probe #(
    .G_ADDR_WIDTH(3), .G_VER_ADDR(4), .G_EXP_MAJOR(1), .G_MIN_MINOR(2),
    .G_TIMEOUT(16), .G_RETRIES(1)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i),
    .busy_o(busy_o), .done_o(done_o), .compat_o(compat_o), .err_o(err_o),
    .timeout_o(timeout_o), .version_o(version_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] dat;
    int          kind;     // 0 ack, 1 err+ack, 2 rty+ack
    int          n_stall;
    int          delay;
    logic        compat;
    logic        err;
    logic        tmo;
    logic [31:0] ver;
  } vec_t;

  typedef struct {
    logic        compat;
    logic        err;
    logic        tmo;
    logic [31:0] ver;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  exp_t e_pop;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  // Scoreboard: every done_o pulse must match the oldest pushed expectation
  always @(negedge clk_i) begin
    if (done_o) begin
      done_cnt++;
      chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: got done_o=1 expected no completion");
      end else begin
        e_pop = sb_q.pop_front();
        chk("compat_o", {31'd0, compat_o}, {31'd0, e_pop.compat});
        chk("err_o", {31'd0, err_o}, {31'd0, e_pop.err});
        chk("timeout_o", {31'd0, timeout_o}, {31'd0, e_pop.tmo});
        chk("version_o", version_o, e_pop.ver);
      end
    end
    prev_done <= done_o;
  end

  task automatic push_exp(input logic c, input logic er, input logic t, input logic [31:0] v);
    exp_t x;
    x.compat = c; x.err = er; x.tmo = t; x.ver = v;
    sb_q.push_back(x);
  endtask

  task automatic drive_term(input int kind, input logic on);
    wb_ack_i = on;
    wb_err_i = on && (kind == 1);
    wb_rty_i = on && (kind == 2);
  endtask

  task automatic start_probe();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int g = 0;
    while (done_cnt == prev && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    if (done_cnt == prev) begin
      n_checks++;
      $display("FAIL wait_done: got no done_o within 100 cycles expected a done_o pulse");
    end
  endtask

  // Acts as the slave for one request: stalls, then terminates after 'delay'
  task automatic attempt(input int kind, input logic [31:0] dat, input int n_stall, input int delay);
    int guard = 0;
    int stb_n = 0;
    int late_stb = 0;
    while (!wb_stb_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    chk("stb_seen", {31'd0, wb_stb_o}, 32'd1);
    chk("req_bus", {24'd0, wb_we_o, wb_sel_o, wb_adr_o}, {24'd0, 1'b0, 4'hF, 3'd4});
    for (int i = 0; i < n_stall; i++) begin
      if (wb_stb_o) stb_n++;
      wb_stall_i = 1'b1;
      @(negedge clk_i);
    end
    if (wb_stb_o) stb_n++;
    wb_stall_i = 1'b0;
    wb_dat_i = dat;
    if (delay == 0) drive_term(kind, 1'b1);
    for (int d = 1; d <= delay; d++) begin
      @(negedge clk_i);
      if (wb_stb_o) late_stb++;
      if (d == delay) drive_term(kind, 1'b1);
    end
    @(negedge clk_i);
    drive_term(kind, 1'b0);
    chk("stb_cycles", stb_n, n_stall + 1);
    chk("stb_after_accept", late_stb, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    int prev;
    int cnt;
    vecs[0] = '{32'h00010203, 0, 0, 2, 1'b1, 1'b0, 1'b0, 32'h00010203};
    vecs[1] = '{32'h00010103, 0, 0, 2, 1'b0, 1'b0, 1'b0, 32'h00010103};
    vecs[2] = '{32'h00020203, 0, 0, 2, 1'b0, 1'b0, 1'b0, 32'h00020203};
    vecs[3] = '{32'hFF010203, 0, 0, 2, 1'b1, 1'b0, 1'b0, 32'hFF010203};
    vecs[4] = '{32'h00010200, 0, 0, 0, 1'b1, 1'b0, 1'b0, 32'h00010200};
    vecs[5] = '{32'hDEADBEEF, 1, 0, 1, 1'b0, 1'b1, 1'b0, 32'h00010200};
    vecs[6] = '{32'h0001FF00, 0, 3, 2, 1'b1, 1'b0, 1'b0, 32'h0001FF00};
    vecs[7] = '{32'h00000503, 0, 0, 3, 1'b0, 1'b0, 1'b0, 32'h00000503};

    repeat (3) @(negedge clk_i);
    chk("rst_bus", {24'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_status", {27'd0, busy_o, done_o, compat_o, err_o, timeout_o}, 32'd0);
    chk("rst_version", version_o, 32'd0);
    rst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].compat, vecs[i].err, vecs[i].tmo, vecs[i].ver);
      prev = done_cnt;
      start_probe();
      attempt(vecs[i].kind, vecs[i].dat, vecs[i].n_stall, vecs[i].delay);
      wait_done(prev);
    end

    // No response: cycle held for exactly G_TIMEOUT cycles
    push_exp(1'b0, 1'b0, 1'b1, 32'h00000503);
    prev = done_cnt;
    start_probe();
    cnt = 0;
    while (wb_cyc_o && cnt < 100) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("timeout_cyc_cycles", cnt, 16);
    wait_done(prev);

    // rty, one idle cycle, rty again with no retries left -> err
    push_exp(1'b0, 1'b1, 1'b0, 32'h00000503);
    prev = done_cnt;
    start_probe();
    attempt(2, 32'h11111111, 0, 1);
    cnt = 0;
    while (!wb_cyc_o && cnt < 10) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("backoff_cycles", cnt, 1);
    attempt(2, 32'h22222222, 0, 1);
    wait_done(prev);

    // rty then ack
    push_exp(1'b1, 1'b0, 1'b0, 32'h00010203);
    prev = done_cnt;
    start_probe();
    attempt(2, 32'h33333333, 0, 1);
    attempt(0, 32'h00010203, 0, 2);
    wait_done(prev);

    // start while busy is ignored; stray ack while idle is ignored
    push_exp(1'b1, 1'b0, 1'b0, 32'h00010204);
    prev = done_cnt;
    start_probe();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wb_dat_i = 32'h00010204;
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    wait_done(prev);
    @(negedge clk_i);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy_o) cnt++;
      @(negedge clk_i);
    end
    chk("no_queued_start", cnt, 0);
    prev = done_cnt;
    wb_dat_i = 32'h12345678;
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ack_ignored", version_o, 32'h00010204);
    chk("idle_ack_no_done", done_cnt, prev);

    // Reset mid-WAIT abandons the cycle
    prev = done_cnt;
    start_probe();
    @(negedge clk_i);
    chk("wait_cyc_before_rst", {31'd0, wb_cyc_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("rst_async_bus", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_async_version", version_o, 32'd0);
    chk("rst_async_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    wb_dat_i = 32'h00010203;
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("rst_no_done", done_cnt, prev);
    chk("rst_version_after", version_o, 32'd0);
    chk("rst_compat_after", {31'd0, compat_o}, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
